// File: rtl/vga_rect_fill.sv
// Avalon-MM write master that fills an axis-aligned frame-buffer rectangle with one colour.
// Optional clipping to the WIDTH x HEIGHT frame is enabled by defining VGA_RECT_FILL_CLIP_EN.
module vga_rect_fill #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [31:0]               cmd_top_left,
   input  logic [31:0]               cmd_bottom_right,
   input  logic [11:0]               cmd_color,
   input  logic [ADDR_WIDTH-1:0]     cmd_base_address,
   output logic [ADDR_WIDTH-1:0]     m_address,
   output logic                      m_write,
   output logic [DATA_WIDTH-1:0]     m_writedata,
   output logic [DATA_WIDTH/8-1:0]   m_byteenable,
   input  logic                      m_waitrequest,
   output logic                      busy,
   output logic                      done
);

   localparam int                    BPP        = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] PIX_STRIDE = ADDR_WIDTH'(BPP);
   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(WIDTH * BPP);
   localparam logic [15:0]           X_MAX      = 16'(WIDTH - 1);
   localparam logic [15:0]           Y_MAX      = 16'(HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WRITE,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0]           x0, y0, x1, y1;
   logic [15:0]           x, y;
   logic [11:0]           color;
   logic [ADDR_WIDTH-1:0] base_addr, row_addr, cur_addr;
   logic [15:0]           x1_eff, y1_eff;
   logic                  empty;
   logic                  accept, x_more, y_more;

   function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [15:0]           px,
      input logic [15:0]           py
   );
      return base + (ADDR_WIDTH'(py) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(px)) * PIX_STRIDE;
   endfunction

`ifdef VGA_RECT_FILL_CLIP_EN
   always_comb begin
      x1_eff = (x1 > X_MAX) ? X_MAX : x1;
      y1_eff = (y1 > Y_MAX) ? Y_MAX : y1;
      empty  = (x0 > X_MAX) || (y0 > Y_MAX) || (x1_eff < x0) || (y1_eff < y0);
   end
`else
   // Frame limits only matter when clipping is built in.
   logic unused_frame_limits;
   assign unused_frame_limits = ^{X_MAX, Y_MAX};

   always_comb begin
      x1_eff = x1;
      y1_eff = y1;
      empty  = (x1 < x0) || (y1 < y0);
   end
`endif

   assign accept = (state == WRITE) && !m_waitrequest;
   assign x_more = (x < x1);
   assign y_more = (y < y1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cmd_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      m_write      = 1'b0;
      m_address    = cur_addr;
      m_writedata  = '0;
      m_byteenable = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            busy      = 1'b1;
            state_nxt = empty ? DONE : WRITE;
         end
         WRITE: begin
            busy         = 1'b1;
            m_write      = 1'b1;
            m_writedata  = {{(DATA_WIDTH-12){1'b0}}, color};
            m_byteenable = '1;
            if (accept && !x_more && !y_more) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command capture and raster walk; these only matter once a command is accepted.
   always_ff @(posedge clk) begin
      if (state == IDLE && cmd_valid) begin
         x0        <= cmd_top_left[31:16];
         y0        <= cmd_top_left[15:0];
         x1        <= cmd_bottom_right[31:16];
         y1        <= cmd_bottom_right[15:0];
         color     <= cmd_color;
         base_addr <= cmd_base_address;
      end
      if (state == SETUP) begin
         x        <= x0;
         y        <= y0;
         x1       <= x1_eff;
         y1       <= y1_eff;
         row_addr <= pixel_addr(base_addr, x0, y0);
      end
      if (accept) begin
         if (x_more) begin
            x <= x + 16'd1;
         end else if (y_more) begin
            x        <= x0;
            y        <= y + 16'd1;
            row_addr <= row_addr + ROW_STRIDE;
         end
      end
   end

   // Write address is visible on m_address, so it carries the reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_addr <= '0;
      end else if (state == SETUP) begin
         cur_addr <= pixel_addr(base_addr, x0, y0);
      end else if (accept) begin
         if (x_more)      cur_addr <= cur_addr + PIX_STRIDE;
         else if (y_more) cur_addr <= row_addr + ROW_STRIDE;
      end
   end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised self-checking bench for vga_rect_fill against a pixel-list reference model.
// Honours VGA_RECT_FILL_CLIP_EN in the model when the macro is defined for the build.
module tb_vga_rect_fill;

   localparam int W = 640;
   localparam int H = 480;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_top_left;
   logic [31:0] cmd_bottom_right;
   logic [11:0] cmd_color;
   logic [31:0] cmd_base_address;
   logic [31:0] m_address;
   logic        m_write;
   logic [15:0] m_writedata;
   logic [1:0]  m_byteenable;
   logic        m_waitrequest;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   vga_rect_fill #(
      .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(32), .DATA_WIDTH(16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_top_left     (cmd_top_left),
      .cmd_bottom_right (cmd_bottom_right),
      .cmd_color        (cmd_color),
      .cmd_base_address (cmd_base_address),
      .m_address        (m_address),
      .m_write          (m_write),
      .m_writedata      (m_writedata),
      .m_byteenable     (m_byteenable),
      .m_waitrequest    (m_waitrequest),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: list every pixel address of the (optionally clipped) rectangle in row-major order.
   function automatic void build_model(input int x0, input int y0, input int x1, input int y1,
                                       input logic [31:0] base);
      int xe, ye;
      exp_q.delete();
      xe = x1;
      ye = y1;
`ifdef VGA_RECT_FILL_CLIP_EN
      if (x0 >= W || y0 >= H) return;
      if (xe > W - 1) xe = W - 1;
      if (ye > H - 1) ye = H - 1;
`endif
      for (int yy = y0; yy <= ye; yy++)
         for (int xx = x0; xx <= xe; xx++)
            exp_q.push_back(base + 32'((yy * W + xx) * 2));
   endfunction

   task automatic issue_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [11:0] color, input logic [31:0] base);
      @(posedge clk); #1;
      cmd_valid        = 1'b1;
      cmd_top_left     = {16'(x0), 16'(y0)};
      cmd_bottom_right = {16'(x1), 16'(y1)};
      cmd_color        = color;
      cmd_base_address = base;
      @(negedge clk);
      check_eq("cmd_ready_idle", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid        = 1'b0;
      cmd_top_left     = $urandom;
      cmd_bottom_right = $urandom;
      cmd_color        = 12'($urandom);
      cmd_base_address = $urandom;
      @(negedge clk);
      check_eq("setup_busy", busy, 1'b1);
      check_eq("setup_write", m_write, 1'b0);
      check_eq("setup_ready", cmd_ready, 1'b0);
   endtask

   task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [11:0] color, input logic [31:0] base,
                          input int stall_pct, input int stall_beat, input int stall_len,
                          output int n_wr, output logic [31:0] first_addr, output int done_cyc);
      int  beats, stalled;
      bit  done_seen;
      build_model(x0, y0, x1, y1, base);
      n_wr       = 0;
      first_addr = '0;
      done_cyc   = -1;
      beats      = 0;
      stalled    = 0;
      done_seen  = 0;
      issue_cmd(x0, y0, x1, y1, color, base);
      for (int cyc = 2; cyc < 4000 && !done_seen; cyc++) begin
         @(posedge clk); #1;
         if (stall_beat == beats && stalled < stall_len) begin
            m_waitrequest = 1'b1;
            stalled++;
         end else begin
            m_waitrequest = ($urandom_range(0, 99) < stall_pct);
         end
         @(negedge clk);
         if (m_write && !m_waitrequest) begin
            if (n_wr == 0) first_addr = m_address;
            n_wr++;
         end
         if (exp_q.size() > 0) begin
            check_eq("wr_valid", m_write, 1'b1);
            check_eq("wr_addr", m_address, exp_q[0]);
            check_eq("wr_data", m_writedata, {4'b0, color});
            check_eq("wr_be", m_byteenable, 2'b11);
            check_eq("wr_done_low", done, 1'b0);
            if (!m_waitrequest) begin
               void'(exp_q.pop_front());
               beats++;
            end
         end else begin
            check_eq("done_pulse", done, 1'b1);
            check_eq("done_no_write", m_write, 1'b0);
            check_eq("done_busy", busy, 1'b1);
            done_cyc  = cyc;
            done_seen = 1;
         end
      end
      if (!done_seen) check_eq("timeout", 1'b0, 1'b1);
      m_waitrequest = 1'b0;
      @(negedge clk);
      check_eq("ret_ready", cmd_ready, 1'b1);
      check_eq("ret_busy", busy, 1'b0);
      check_eq("ret_done", done, 1'b0);
   endtask

   initial begin
      int          n_wr, done_cyc, rx0, ry0, rx1, ry1, exp_n;
      logic [31:0] first_addr, rbase;

      reset            = 1'b1;
      cmd_valid        = 1'b0;
      cmd_top_left     = '0;
      cmd_bottom_right = '0;
      cmd_color        = '0;
      cmd_base_address = '0;
      m_waitrequest    = 1'b0;

      repeat (2) @(negedge clk);
      check_eq("rst_ready", cmd_ready, 1'b1);
      check_eq("rst_write", m_write, 1'b0);
      check_eq("rst_addr", m_address, 32'h0);
      check_eq("rst_data", m_writedata, 16'h0);
      check_eq("rst_be", m_byteenable, 2'b00);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single pixel
      run_cmd(10, 20, 10, 20, 12'hF00, 32'h1000, 0, -1, 0, n_wr, first_addr, done_cyc);
      check_eq("sp_count", n_wr, 1);
      check_eq("sp_addr", first_addr, 32'h7414);
      check_eq("sp_done_cyc", done_cyc, 3);

      // 3x2 rectangle, no stalls
      run_cmd(0, 0, 2, 1, 12'h0A5, 32'h0, 0, -1, 0, n_wr, first_addr, done_cyc);
      check_eq("r32_count", n_wr, 6);
      check_eq("r32_first", first_addr, 32'h0);
      check_eq("r32_done_cyc", done_cyc, 8);

      // 3x2 rectangle, 3-cycle stall on the second beat
      run_cmd(0, 0, 2, 1, 12'h5A5, 32'h0, 0, 1, 3, n_wr, first_addr, done_cyc);
      check_eq("stall_count", n_wr, 6);
      check_eq("stall_done_cyc", done_cyc, 11);

      // Empty rectangle
      run_cmd(5, 5, 4, 5, 12'h123, 32'h0, 0, -1, 0, n_wr, first_addr, done_cyc);
      check_eq("empty_count", n_wr, 0);
      check_eq("empty_done_cyc", done_cyc, 2);

      // Rectangle straddling the bottom-right frame corner
`ifdef VGA_RECT_FILL_CLIP_EN
      exp_n = 2;
`else
      exp_n = 1386;
`endif
      run_cmd(638, 479, 700, 500, 12'hFFF, 32'h0, 0, -1, 0, n_wr, first_addr, done_cyc);
      check_eq("clip_count", n_wr, exp_n);
      check_eq("clip_first", first_addr, 32'd614396);
      check_eq("clip_done_cyc", done_cyc, exp_n + 2);

      // Reset in the middle of a 10x10 fill
      issue_cmd(100, 100, 109, 109, 12'h777, 32'h0010_0000);
      n_wr = 0;
      for (int cyc = 2; cyc < 50 && n_wr < 3; cyc++) begin
         @(negedge clk);
         if (m_write && !m_waitrequest) n_wr++;
      end
      check_eq("mid_beats", n_wr, 3);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_write", m_write, 1'b0);
      check_eq("mid_rst_done", done, 1'b0);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("post_rst_done", done, 1'b0);
         check_eq("post_rst_write", m_write, 1'b0);
         check_eq("post_rst_ready", cmd_ready, 1'b1);
      end
      run_cmd(10, 20, 10, 20, 12'h0F0, 32'h1000, 0, -1, 0, n_wr, first_addr, done_cyc);
      check_eq("post_rst_count", n_wr, 1);
      check_eq("post_rst_addr", first_addr, 32'h7414);

      // Randomised commands with random backpressure
      for (int t = 0; t < 25; t++) begin
         rx0 = $urandom_range(0, 700);
         ry0 = $urandom_range(0, 500);
         rx1 = rx0 + $urandom_range(0, 5);
         ry1 = ry0 + $urandom_range(0, 5);
         if ($urandom_range(0, 5) == 0 && rx0 > 0) rx1 = rx0 - 1;
         if ($urandom_range(0, 5) == 0 && ry0 > 0) ry1 = ry0 - 1;
         rbase = $urandom;
         build_model(rx0, ry0, rx1, ry1, rbase);
         exp_n = exp_q.size();
         run_cmd(rx0, ry0, rx1, ry1, 12'($urandom), rbase, $urandom_range(0, 40), -1, 0,
                 n_wr, first_addr, done_cyc);
         check_eq("rand_count", n_wr, exp_n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Avalon-MM write master that fills an axis-aligned rectangle of the frame buffer with one 12-bit colour. It is the writer side of the frame buffer that the VGA prefetcher reads: a command (top-left, bottom-right, colour, base address) is accepted over a valid/ready handshake. The block then issues one single-word pixel write per pixel, row-major, into the 640x480, 16-bit-per-pixel frame buffer. It sits between the drawing/CPU logic and the memory interconnect, alongside the CSR-driven stream blocks.

## Interface
- WIDTH, 640, frame buffer width in pixels (row pitch)
- HEIGHT, 480, frame buffer height in pixels
- ADDR_WIDTH, 32, Avalon-MM byte address width
- DATA_WIDTH, 16, pixel word width; byte stride per pixel = DATA_WIDTH/8
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on the cycle where cmd_valid && cmd_ready
- cmd_top_left  in  32  coordinate_t {x[31:16], y[15:0]}, inclusive
- cmd_bottom_right  in  32  coordinate_t, inclusive
- cmd_color  in  12  pixel colour
- cmd_base_address  in  ADDR_WIDTH  byte address of pixel (0,0)
- m_address  out  ADDR_WIDTH  write byte address
- m_write  out  1  write request
- m_writedata  out  DATA_WIDTH  {4'b0, colour}
- m_byteenable  out  DATA_WIDTH/8  all ones while m_write is asserted
- m_waitrequest  in  1  slave stall
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at command completion

## Operation
- FSM states: IDLE, SETUP, WRITE, DONE.
- IDLE: cmd_ready=1. On handshake, register all cmd fields and go to SETUP.
- SETUP (1 cycle):
  - Compute row_addr = base + (y0*WIDTH + x0)*2, modulo 2^ADDR_WIDTH.
  - Set x=x0, y=y0.
  - If x1<x0 or y1<y0 (unsigned 16-bit compare), go to DONE; otherwise go to WRITE.
- WRITE:
  - m_write=1, m_address=cur_addr, m_writedata={4'b0,colour}.
  - A beat is accepted when m_write && !m_waitrequest.
  - On accept, if x<x1: x++, cur_addr+=2.
  - On accept, else if y<y1: y++, x=x0, row_addr+=WIDTH*2, cur_addr=new row_addr.
  - On accept, else: go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
- busy is high in SETUP, WRITE and DONE.
- While m_waitrequest=1, m_address, m_writedata and m_write are held stable (Avalon rule).
- No reads are issued. Only one command is in flight; cmd_ready=0 outside IDLE.
- Counters are 16 bits and the x1/y1 compare is inclusive, so x1=0xFFFF cannot overflow x.

## Timing
- Reset values: cmd_ready=1, m_write=0, m_address=0, m_writedata=0, m_byteenable=0, busy=0, done=0, FSM=IDLE.
- Reset asserted mid-fill: m_write drops immediately (asynchronous). The in-flight write is abandoned and no done pulse is produced.
- Handshake at cycle 0; SETUP at cycle 1; first m_write at cycle 2.
- With waitrequest low, one pixel is written per cycle, including across row boundaries (no bubble).
- done is asserted the cycle after the last accepted beat; cmd_ready=1 the cycle after done.
- Empty rectangle: done at cycle 2, with no m_write.
- Total cycles for an NxM fill with no stalls: N*M + 3 (handshake to cmd_ready return).

## Configuration
- Macro VGA_RECT_FILL_CLIP_EN.
- Defined: in SETUP, x1 is clamped to WIDTH-1 and y1 to HEIGHT-1. If x0>=WIDTH or y0>=HEIGHT, the command is treated as empty.
- Undefined: coordinates are used unmodified; out-of-range writes go wherever the address arithmetic points, and the caller is responsible.

## Test plan
- Single pixel: (10,20)-(10,20), colour 0xF00, base 0x1000 -> exactly one write, addr 0x7414, data 0x0F00, byteenable 2'b11; done one cycle after accept.
- 3x2 rectangle: (0,0)-(2,1), base 0 -> writes to 0, 2, 4, 1280, 1282, 1284 on consecutive cycles; done at cycle 8.
- Stall: same 3x2 rectangle with m_waitrequest high for 3 cycles on the 2nd beat -> address 2 and its data are held stable throughout; still exactly 6 writes; done is delayed by 3 cycles.
- Empty rectangle: (5,5)-(4,5) -> no m_write; done at cycle 2; busy high for cycles 1-2.
- Clip, with VGA_RECT_FILL_CLIP_EN defined: (638,479)-(700,500), base 0 -> 2 writes, addr 614396 and 614398. Without the macro -> 1386 writes (63x22).
- Reset mid-fill: assert reset after the 3rd accepted beat of a 10x10 fill -> m_write=0 in the same cycle; no done pulse; after release, cmd_ready=1 and a new single-pixel command completes normally.
